// File: rtl/icache_resp.sv
`default_nettype none
// ============================================================================
// Module   : icache_resp
// Purpose  : Direct-mapped instruction cache front end. It has 8 lines of
//            4 x 32-bit words. Hits return data combinationally in the
//            same cycle. Misses stall the fetch and run a 4-beat line fill
//            from backing memory.
// Ports    : clk        - single clock, all state on rising edge
//            rst        - asynchronous reset, active low
//            addr       - byte fetch address (held while ready=0)
//            enable     - fetch request valid
//            flush      - invalidate every line, abort any fill
//            data_out   - instruction word (NOP when nothing to return)
//            ready      - data_out valid this cycle, 0 = stall
//            err        - misaligned fetch (addr[1:0] != 0)
//            mem_req    - line-fill request, high for the whole fill
//            mem_addr   - word address of the beat being requested
//            mem_data   - returned word from backing memory
//            mem_valid  - mem_data valid this cycle
//            hit_cnt    - hit performance counter (16 bit, saturating)
//            miss_cnt   - miss performance counter (16 bit, saturating)
// Config   : define ICACHE_PERF_CNT_EN to build the performance counters.
//            Without it, hit_cnt and miss_cnt are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module icache_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        enable,
    input  logic        flush,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_valid,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_valid;
    logic [24:0] r_tag  [0:7];
    logic [31:0] r_data [0:31];
    logic [27:0] r_line_base;
    logic [1:0]  r_cnt;

    logic [24:0] w_tag;
    logic [2:0]  w_index;
    logic [1:0]  w_word;
    logic        w_aligned;
    logic        w_idle;
    logic        w_hit;
    logic        w_start_fill;
    logic        w_beat;
    logic        w_fill_done;
    logic [2:0]  w_fill_index;
    logic [31:0] w_lookup;

    assign w_tag        = addr[31:7];
    assign w_index      = addr[6:4];
    assign w_word       = addr[3:2];
    assign w_aligned    = (addr[1:0] == 2'b00);
    assign w_idle       = (r_state == ST_IDLE);
    assign w_fill_index = r_line_base[2:0];
    assign w_lookup     = r_data[{w_index, w_word}];

    assign w_hit        = enable && w_aligned && w_idle && r_valid[w_index]
                          && (r_tag[w_index] == w_tag);
    // Flush wins over starting a fill, so the FSM stays in IDLE.
    assign w_start_fill = enable && w_aligned && w_idle && !w_hit && !flush;
    assign w_beat       = (r_state == ST_FILL) && mem_valid;
    assign w_fill_done  = w_beat && (r_cnt == 2'd3);

    assign err      = enable && !w_aligned;
    assign mem_req  = (r_state == ST_FILL);
    assign mem_addr = {r_line_base, r_cnt, 2'b00};

    // ------------------------------------------------------------------------
    // Next state and fetch-side outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        data_out    = C_NOP;

        case (r_state)
            ST_IDLE: begin
                if (!enable || !w_aligned) begin
                    ready = 1'b1;
                end else if (w_hit) begin
                    ready    = 1'b1;
                    data_out = w_lookup;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_fill_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A flush cycle never returns data. This includes a hit in the same
        // cycle, because the line is being invalidated.
        if (flush) begin
            ready       = 1'b0;
            data_out    = C_NOP;
            w_state_nxt = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Control state: FSM, valid bits, fill pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_valid     <= '0;
            r_cnt       <= 2'd0;
            r_line_base <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_valid <= '0;
                r_cnt   <= 2'd0;
            end else if (w_start_fill) begin
                // The victim line is dropped right away, so a partial
                // overwrite can never be seen as valid.
                r_line_base       <= addr[31:4];
                r_cnt             <= 2'd0;
                r_valid[w_index]  <= 1'b0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_valid[w_fill_index] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage arrays: contents are qualified by r_valid, so they need no reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_beat && !flush) begin
            r_data[{w_fill_index, r_cnt}] <= mem_data;
        end
        if (w_fill_done && !flush) begin
            r_tag[w_fill_index] <= r_line_base[27:3];
        end
    end

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef ICACHE_PERF_CNT_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= 16'd0;
            r_miss_cnt <= 16'd0;
        end else begin
            // Count only hit cycles that actually deliver data.
            if (w_hit && !flush && (r_hit_cnt != 16'hFFFF)) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (w_start_fill && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = 16'd0;
    assign miss_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_resp
// Purpose  : Self-checking bench for icache_resp. It applies a table of
//            single-cycle vectors and then runs hand-written sequences for
//            flush, reset and counter corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_resp;

    localparam logic [31:0] C_NOP = 32'h0000_0013;
`ifdef ICACHE_PERF_CNT_EN
    localparam logic [15:0] C_EXP_HITS   = 16'd5;
    localparam logic [15:0] C_EXP_MISSES = 16'd1;
`else
    localparam logic [15:0] C_EXP_HITS   = 16'd0;
    localparam logic [15:0] C_EXP_MISSES = 16'd0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        enable;
    logic        flush;
    logic [31:0] data_out;
    logic        ready;
    logic        err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    icache_resp dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .enable    (enable),
        .flush     (flush),
        .data_out  (data_out),
        .ready     (ready),
        .err       (err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_valid (mem_valid),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        fl;
        logic [31:0] a;
        logic        mv;
        logic [31:0] md;
        logic        e_rdy;
        logic [31:0] e_data;
        logic        e_err;
        logic        e_req;
        logic        chk_ma;
        logic [31:0] e_ma;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    // Backing-memory contents: every word is tagged with its own address.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    function automatic vec_t mk(input logic en, input logic fl, input logic [31:0] a,
                                input logic mv, input logic [31:0] md,
                                input logic rdy, input logic [31:0] dat,
                                input logic er, input logic req,
                                input logic chk, input logic [31:0] ma);
        vec_t v;
        v.en = en; v.fl = fl; v.a = a; v.mv = mv; v.md = md;
        v.e_rdy = rdy; v.e_data = dat; v.e_err = er; v.e_req = req;
        v.chk_ma = chk; v.e_ma = ma;
        return v;
    endfunction

    function automatic vec_t vmiss(input logic [31:0] a);
        return mk(1'b1, 1'b0, a, 1'b0, 32'h0, 1'b0, C_NOP, 1'b0, 1'b0, 1'b0, 32'h0);
    endfunction

    function automatic vec_t vhit(input logic [31:0] a);
        return mk(1'b1, 1'b0, a, 1'b0, 32'h0, 1'b1, mw(a), 1'b0, 1'b0, 1'b0, 32'h0);
    endfunction

    function automatic vec_t vbeat(input logic [31:0] a, input logic [31:0] base,
                                   input int k, input logic fl);
        logic [31:0] wa;
        wa = base + 32'(k * 4);
        return mk(1'b1, fl, a, 1'b1, mw(wa), 1'b0, C_NOP, 1'b0, 1'b1, 1'b1, wa);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
    task automatic apply(input vec_t v, input string nm);
        vec_t e;
        enable    = v.en;
        flush     = v.fl;
        addr      = v.a;
        mem_valid = v.mv;
        mem_data  = v.md;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("%s.ready", nm), {31'b0, ready}, {31'b0, e.e_rdy});
        chk($sformatf("%s.data_out", nm), data_out, e.e_data);
        chk($sformatf("%s.err", nm), {31'b0, err}, {31'b0, e.e_err});
        chk($sformatf("%s.mem_req", nm), {31'b0, mem_req}, {31'b0, e.e_req});
        if (e.chk_ma) begin
            chk($sformatf("%s.mem_addr", nm), mem_addr, e.e_ma);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill_line(input logic [31:0] a, input string nm);
        logic [31:0] base;
        base = {a[31:4], 4'h0};
        apply(vmiss(a), $sformatf("%s.miss", nm));
        for (int k = 0; k < 4; k++) begin
            apply(vbeat(a, base, k, 1'b0), $sformatf("%s.beat%0d", nm, k));
        end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        // ---------------- vector table ----------------
        tbl.push_back(mk(1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, C_NOP, 1'b0, 1'b0, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h102, 1'b0, 32'h0, 1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 32'h0));
        tbl.push_back(vmiss(32'h100));
        for (int k = 0; k < 4; k++) tbl.push_back(vbeat(32'h100, 32'h100, k, 1'b0));
        tbl.push_back(vhit(32'h100));
        tbl.push_back(vhit(32'h108));
        tbl.push_back(vhit(32'h10C));
        tbl.push_back(vhit(32'h104));
        // Stray mem_valid in IDLE must not disturb the cached line.
        tbl.push_back(mk(1'b1, 1'b0, 32'h108, 1'b1, 32'hDEAD_BEEF, 1'b1, mw(32'h108), 1'b0, 1'b0, 1'b0, 32'h0));
        tbl.push_back(vhit(32'h108));
        tbl.push_back(mk(1'b0, 1'b0, 32'h104, 1'b0, 32'h0, 1'b1, C_NOP, 1'b0, 1'b0, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h10E, 1'b0, 32'h0, 1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 32'h0));
        // Same index, new tag: evicts 0x100. The fetch address moves mid-fill.
        tbl.push_back(vmiss(32'h180));
        tbl.push_back(mk(1'b1, 1'b0, 32'h104, 1'b0, 32'h0, 1'b0, C_NOP, 1'b0, 1'b1, 1'b1, 32'h180));
        for (int k = 0; k < 4; k++) tbl.push_back(vbeat(32'h104, 32'h180, k, 1'b0));
        tbl.push_back(vhit(32'h188));
        tbl.push_back(vmiss(32'h104));
        for (int k = 0; k < 4; k++) tbl.push_back(vbeat(32'h104, 32'h100, k, 1'b0));
        tbl.push_back(vhit(32'h104));
        tbl.push_back(vmiss(32'h180));
        // Flush while in FILL: ready low, mem_req still up this cycle.
        tbl.push_back(mk(1'b1, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0, C_NOP, 1'b0, 1'b1, 1'b1, 32'h180));
        tbl.push_back(mk(1'b0, 1'b0, 32'h180, 1'b0, 32'h0, 1'b1, C_NOP, 1'b0, 1'b0, 1'b0, 32'h0));

        // ---------------- reset ----------------
        rst = 1'b1; enable = 1'b1; addr = 32'h100; flush = 1'b0;
        mem_valid = 1'b0; mem_data = 32'h0;
        #1 rst = 1'b0;
        #2;
        chk("reset.ready", {31'b0, ready}, 32'h0);
        chk("reset.mem_req", {31'b0, mem_req}, 32'h0);
        chk("reset.data_out", data_out, C_NOP);
        chk("reset.hit_cnt", {16'b0, hit_cnt}, 32'h0);
        chk("reset.miss_cnt", {16'b0, miss_cnt}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // ---------------- flush on the 2nd beat ----------------
        apply(vmiss(32'h100), "fl2.miss");
        apply(vbeat(32'h100, 32'h100, 0, 1'b0), "fl2.beat0");
        apply(vbeat(32'h100, 32'h100, 1, 1'b1), "fl2.beat1_flush");
        fill_line(32'h100, "fl2.refill");
        apply(vhit(32'h100), "fl2.hit");

        // ---------------- flush on the 4th beat ----------------
        apply(vmiss(32'h140), "fl4.miss");
        for (int k = 0; k < 3; k++) apply(vbeat(32'h140, 32'h140, k, 1'b0), $sformatf("fl4.beat%0d", k));
        apply(vbeat(32'h140, 32'h140, 3, 1'b1), "fl4.beat3_flush");
        fill_line(32'h140, "fl4.refill");
        apply(vhit(32'h148), "fl4.hit");

        // ---------------- reset mid-fill ----------------
        apply(vmiss(32'h100), "rstf.miss");
        for (int k = 0; k < 3; k++) apply(vbeat(32'h100, 32'h100, k, 1'b0), $sformatf("rstf.beat%0d", k));
        enable = 1'b1; addr = 32'h100; mem_valid = 1'b0; flush = 1'b0;
        #1;
        chk("rstf.pre_mem_req", {31'b0, mem_req}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rstf.mem_req", {31'b0, mem_req}, 32'h0);
        chk("rstf.ready", {31'b0, ready}, 32'h0);
        chk("rstf.hit_cnt", {16'b0, hit_cnt}, 32'h0);
        chk("rstf.miss_cnt", {16'b0, miss_cnt}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // ---------------- counters: 1 miss then 5 hits ----------------
        fill_line(32'h100, "cnt.fill");
        apply(vhit(32'h100), "cnt.hit0");
        apply(vhit(32'h104), "cnt.hit1");
        apply(vhit(32'h108), "cnt.hit2");
        apply(vhit(32'h10C), "cnt.hit3");
        apply(vhit(32'h100), "cnt.hit4");
        chk("cnt.hit_cnt", {16'b0, hit_cnt}, {16'b0, C_EXP_HITS});
        chk("cnt.miss_cnt", {16'b0, miss_cnt}, {16'b0, C_EXP_MISSES});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_resp.md
ICACHE_RESP -- requirements
Module: icache_resp

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-low (0 = reset).
REQ-003 SHALL have port addr, input, 32, byte fetch address from the PC flop.
REQ-004 SHALL have port enable, input, 1, fetch request valid.
REQ-005 SHALL have port flush, input, 1, invalidate all lines.
REQ-006 SHALL have port data_out, output, 32, instruction word.
REQ-007 SHALL have port ready, output, 1, data_out valid this cycle; 0 means stall and hold addr.
REQ-008 SHALL have port err, output, 1, misaligned fetch.
REQ-009 SHALL have port mem_req, output, 1, backing-memory line-fill request.
REQ-010 SHALL have port mem_addr, output, 32, backing-memory word address.
REQ-011 SHALL have port mem_data, input, 32, backing-memory return word.
REQ-012 SHALL have port mem_valid, input, 1, mem_data valid this cycle.
REQ-013 SHALL have ports hit_cnt and miss_cnt, output, 16 each, performance counters.

Function
REQ-014 SHALL be direct-mapped: 8 lines of 4 words, with tag addr[31:7], index addr[6:4], word addr[3:2], plus one valid bit per line.
REQ-015 SHALL, on a hit (enable=1, addr[1:0]=0, FSM in IDLE, line valid, tag match), drive ready=1 and data_out=word combinationally in the same cycle, with zero-cycle latency.
REQ-016 SHALL, when enable=0, drive ready=1 and data_out=0x00000013 (NOP) and start no fill.
REQ-017 SHALL, when enable=1 and addr[1:0]!=0, drive err=1, ready=1 and data_out=0x00000013 and start no fill; err=0 otherwise.
REQ-018 SHALL implement a two-state FSM: IDLE -> FILL on an aligned enabled miss in IDLE (latching line base addr[31:4]); FILL -> IDLE after the 4th mem_valid beat.
REQ-019 SHALL, in FILL, hold mem_req=1 and drive mem_addr={line_base,cnt[1:0],2'b00}; cnt starts at 0 and increments on each mem_valid.
REQ-020 SHALL write mem_data into word cnt on each mem_valid, and set the tag and valid bit on the 4th beat.
REQ-021 SHALL keep ready=0, data_out=0x00000013 and mem_req=0 in IDLE on a miss cycle, and ready=0 throughout FILL.
REQ-022 SHALL let the fill complete for the latched line even if addr changes mid-fill; the next cycle re-evaluates the current addr.
REQ-023 SHALL ignore mem_valid outside FILL.
REQ-024 SHALL, on flush=1, clear all valid bits at the clock edge, force the FSM to IDLE, clear cnt, drop mem_req the next cycle, and drive ready=0 during the flush cycle; flush has priority over a completing 4th beat (line not validated).

Reset
REQ-025 SHALL, while rst=0, asynchronously clear all valid bits, FSM=IDLE, cnt=0, mem_req=0, hit_cnt=0 and miss_cnt=0.
REQ-026 SHALL abort any fill in progress on reset with no partial line marked valid; data array contents need no reset.
REQ-027 SHALL make outputs during reset follow the combinational rules above with all lines invalid (enabled aligned fetch gives ready=0).

Configuration
REQ-028 SHALL, with macro ICACHE_PERF_CNT_EN defined, increment hit_cnt once per hit cycle (REQ-015) and miss_cnt once per IDLE->FILL transition, both saturating at 0xFFFF.
REQ-029 SHALL, without ICACHE_PERF_CNT_EN, keep the ports present but tie hit_cnt and miss_cnt to 0 with no counter flops.

Verification
REQ-030 SHALL cover: after reset, addr=0x100, enable=1 -> ready=0, mem_req=1, mem_addr 0x100,0x104,0x108,0x10C; on mem_valid data A0..A3 -> ready=1, data_out=A0 the cycle after the 4th beat.
REQ-031 SHALL cover: after that fill, addr=0x108 -> ready=1, data_out=A2 the same cycle with no mem_req; addr=0x180 (same index, new tag) -> miss, refill evicts; then 0x100 misses again.
REQ-032 SHALL cover: addr=0x102, enable=1 -> err=1, ready=1, data_out=0x00000013, mem_req stays 0.
REQ-033 SHALL cover: flush asserted together with the 2nd mem_valid beat -> mem_req=0 next cycle, FSM IDLE, and addr 0x100 misses again.
REQ-034 SHALL cover: rst pulsed low mid-fill (after 3 beats) -> mem_req=0 immediately and a line 0x100 re-fetch misses.
REQ-035 SHALL cover: with ICACHE_PERF_CNT_EN, 1 miss followed by 5 hits -> miss_cnt=1, hit_cnt=5; without the macro both read 0.
